// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: holds one FPU operation in flight and times its writeback.
// A latency class is decoded from FPU_SELECT when an operation is accepted.
// A 5-bit down-counter then walks the FSM through EXEC into WB.
// Only one operation can be in flight, so issue is stalled while executing.
// Handshake: ISSUE_VALID presents an operation, and FPU_START marks the cycle
// it is taken. When STALL is high, issue must hold the same operation stable.
// An operation with ISSUE_VALID high that sees neither FPU_START nor STALL was
// refused: it was illegal (ILLEGAL_OP) or it was killed by FLUSH.
module fpu_op_scheduler #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 14,
  parameter int unsigned LAT_FMA  = 5,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ISSUE_VALID,
  input  logic [4:0] FPU_SELECT,
  input  logic [4:0] RD,
  input  logic       FREG_WRITE_EN_IN,
  input  logic       REG_WRITE_EN_IN,
  input  logic       FLUSH,
  output logic       FPU_START,
  output logic [4:0] FPU_OP,
  output logic       STALL,
  output logic       ILLEGAL_OP,
  output logic       BUSY,
  output logic       WB_VALID,
  output logic [4:0] WB_RD,
  output logic       WB_FREG_EN,
  output logic       WB_REG_EN
);

  localparam logic [4:0] L_ADD  = 5'(LAT_ADD);
  localparam logic [4:0] L_MUL  = 5'(LAT_MUL);
  localparam logic [4:0] L_DIV  = 5'(LAT_DIV);
  localparam logic [4:0] L_SQRT = 5'(LAT_SQRT);
  localparam logic [4:0] L_FMA  = 5'(LAT_FMA);
  localparam logic [4:0] L_MISC = 5'(LAT_MISC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [4:0] rd_q;
  logic       freg_q, reg_q;
  logic       legal, can_accept, accept;
  logic [4:0] lat;

  // Latency class decode. Codes above 20, or any unknown bit, are illegal.
  always_comb begin
    lat   = L_MISC;
    legal = !$isunknown(FPU_SELECT) && (FPU_SELECT <= 5'd20);
    case (FPU_SELECT)
      5'd1, 5'd2:                lat = L_ADD;
      5'd3:                      lat = L_MUL;
      5'd4:                      lat = L_DIV;
      5'd13:                     lat = L_SQRT;
      5'd14, 5'd15, 5'd16, 5'd17: lat = L_FMA;
      default:                   lat = L_MISC;
    endcase
  end

  // Next state, counter, and the combinational issue-side outputs.
  // RESET gates every combinational output so nothing leaks out during reset.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    FPU_START  = 1'b0;
    FPU_OP     = 5'd0;
    STALL      = 1'b0;
    ILLEGAL_OP = 1'b0;
    can_accept = (state == IDLE) || (state == WB);
    accept     = ISSUE_VALID && legal && !FLUSH && can_accept && !RESET;

    case (state)
      IDLE: state_nxt = IDLE;
      EXEC: begin
        // FLUSH wins over completion: the operation simply disappears.
        if (FLUSH)
          state_nxt = IDLE;
        else if (cnt == 5'd1)
          state_nxt = WB;
        else
          cnt_nxt = cnt - 5'd1;
        STALL = ISSUE_VALID && !RESET;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (accept) begin
      FPU_START = 1'b1;
      FPU_OP    = FPU_SELECT;
      if (lat == 5'd1) begin
        state_nxt = WB;
        cnt_nxt   = 5'd0;
      end else begin
        state_nxt = EXEC;
        cnt_nxt   = lat - 5'd1;
      end
    end

    ILLEGAL_OP = ISSUE_VALID && !legal && can_accept && !RESET;
  end

  // State register, counter, and the destination/enables latched on accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      rd_q   <= 5'd0;
      freg_q <= 1'b0;
      reg_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rd_q   <= RD;
        freg_q <= FREG_WRITE_EN_IN;
        reg_q  <= REG_WRITE_EN_IN;
      end
    end
  end

  // These outputs depend only on flops, so they are registered by construction.
  assign BUSY       = (state != IDLE);
  assign WB_VALID   = (state == WB);
  assign WB_RD      = rd_q;
  assign WB_FREG_EN = WB_VALID & freg_q;
  assign WB_REG_EN  = WB_VALID & reg_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed testbench for fpu_op_scheduler.
// Inputs are driven 1 ns after the rising edge and outputs are checked on the
// falling edge. "Cycle 0" is the cycle in which the operation is presented.
module tb_fpu_op_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ISSUE_VALID;
  logic [4:0] FPU_SELECT;
  logic [4:0] RD;
  logic       FREG_WRITE_EN_IN;
  logic       REG_WRITE_EN_IN;
  logic       FLUSH;
  logic       FPU_START;
  logic [4:0] FPU_OP;
  logic       STALL;
  logic       ILLEGAL_OP;
  logic       BUSY;
  logic       WB_VALID;
  logic [4:0] WB_RD;
  logic       WB_FREG_EN;
  logic       WB_REG_EN;

  int errors = 0;
  int checks = 0;

  fpu_op_scheduler dut (
    .CLK(CLK), .RESET(RESET), .ISSUE_VALID(ISSUE_VALID), .FPU_SELECT(FPU_SELECT),
    .RD(RD), .FREG_WRITE_EN_IN(FREG_WRITE_EN_IN), .REG_WRITE_EN_IN(REG_WRITE_EN_IN),
    .FLUSH(FLUSH), .FPU_START(FPU_START), .FPU_OP(FPU_OP), .STALL(STALL),
    .ILLEGAL_OP(ILLEGAL_OP), .BUSY(BUSY), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
    .WB_FREG_EN(WB_FREG_EN), .WB_REG_EN(WB_REG_EN)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    ISSUE_VALID = 1'b0; FPU_SELECT = 5'd0; RD = 5'd0;
    FREG_WRITE_EN_IN = 1'b0; REG_WRITE_EN_IN = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic fen, input logic ren);
    ISSUE_VALID = 1'b1; FPU_SELECT = op; RD = rd;
    FREG_WRITE_EN_IN = fen; REG_WRITE_EN_IN = ren;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    issue(5'd1, 5'd9, 1'b1, 1'b1);
    tick();
    @(negedge CLK);
    checks++; if (FPU_START !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", FPU_START); end
    checks++; if (FPU_OP !== 5'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", FPU_OP); end
    checks++; if ({BUSY, WB_VALID, WB_FREG_EN, WB_REG_EN} !== 4'b0) begin errors++; $display("FAIL reset_regs got=%b exp=0000", {BUSY, WB_VALID, WB_FREG_EN, WB_REG_EN}); end
    checks++; if (WB_RD !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", WB_RD); end
    tick();
    RESET = 1'b0;
    drive_idle();
    tick();
  endtask

  // FADD, L=3: WB at cycle 3 only, BUSY during cycles 1..3.
  task automatic test_fadd();
    issue(5'd1, 5'd5, 1'b1, 1'b0);
    @(negedge CLK);
    checks++; if (FPU_START !== 1'b1) begin errors++; $display("FAIL fadd_start got=%b exp=1", FPU_START); end
    checks++; if (FPU_OP !== 5'd1) begin errors++; $display("FAIL fadd_op got=%0d exp=1", FPU_OP); end
    tick();
    drive_idle();
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checks++; if (WB_VALID !== (c == 3)) begin errors++; $display("FAIL fadd_wb_valid c=%0d got=%b exp=%b", c, WB_VALID, (c == 3)); end
      checks++; if (BUSY !== (c <= 3)) begin errors++; $display("FAIL fadd_busy c=%0d got=%b exp=%b", c, BUSY, (c <= 3)); end
      checks++; if (WB_FREG_EN !== (c == 3)) begin errors++; $display("FAIL fadd_freg_en c=%0d got=%b exp=%b", c, WB_FREG_EN, (c == 3)); end
      if (c == 3) begin
        checks++; if (WB_RD !== 5'd5) begin errors++; $display("FAIL fadd_wb_rd got=%0d exp=5", WB_RD); end
        checks++; if (WB_REG_EN !== 1'b0) begin errors++; $display("FAIL fadd_reg_en got=%b exp=0", WB_REG_EN); end
      end
      tick();
    end
  endtask

  // FDIV (L=12) then a held FMUL: stalled for cycles 1..11, accepted at 12, WB at 15.
  task automatic test_back_to_back();
    issue(5'd4, 5'd7, 1'b1, 1'b0);
    @(negedge CLK);
    checks++; if (FPU_START !== 1'b1) begin errors++; $display("FAIL fdiv_start got=%b exp=1", FPU_START); end
    tick();
    issue(5'd3, 5'd9, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      checks++; if (STALL !== (c <= 11)) begin errors++; $display("FAIL fdiv_stall c=%0d got=%b exp=%b", c, STALL, (c <= 11)); end
      checks++; if (FPU_START !== (c == 12)) begin errors++; $display("FAIL fmul_start c=%0d got=%b exp=%b", c, FPU_START, (c == 12)); end
      checks++; if (WB_VALID !== (c == 12)) begin errors++; $display("FAIL fdiv_wb_valid c=%0d got=%b exp=%b", c, WB_VALID, (c == 12)); end
      if (c == 12) begin
        checks++; if (WB_RD !== 5'd7) begin errors++; $display("FAIL fdiv_wb_rd got=%0d exp=7", WB_RD); end
      end
      tick();
    end
    drive_idle();
    for (int c = 13; c <= 17; c++) begin
      @(negedge CLK);
      checks++; if (WB_VALID !== (c == 15)) begin errors++; $display("FAIL fmul_wb_valid c=%0d got=%b exp=%b", c, WB_VALID, (c == 15)); end
      if (c == 15) begin
        checks++; if (WB_RD !== 5'd9) begin errors++; $display("FAIL fmul_wb_rd got=%0d exp=9", WB_RD); end
      end
      tick();
    end
  endtask

  // FEQ (L=1) then a back-to-back FLE; integer-file write enables only.
  task automatic test_misc_compare();
    issue(5'd10, 5'd3, 1'b0, 1'b1);
    @(negedge CLK);
    checks++; if (FPU_START !== 1'b1) begin errors++; $display("FAIL feq_start got=%b exp=1", FPU_START); end
    tick();
    issue(5'd9, 5'd4, 1'b0, 1'b1);
    @(negedge CLK);
    checks++; if (WB_VALID !== 1'b1) begin errors++; $display("FAIL feq_wb_valid got=%b exp=1", WB_VALID); end
    checks++; if (WB_REG_EN !== 1'b1) begin errors++; $display("FAIL feq_reg_en got=%b exp=1", WB_REG_EN); end
    checks++; if (WB_FREG_EN !== 1'b0) begin errors++; $display("FAIL feq_freg_en got=%b exp=0", WB_FREG_EN); end
    checks++; if (WB_RD !== 5'd3) begin errors++; $display("FAIL feq_wb_rd got=%0d exp=3", WB_RD); end
    checks++; if (FPU_START !== 1'b1) begin errors++; $display("FAIL fle_start got=%b exp=1", FPU_START); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL fle_stall got=%b exp=0", STALL); end
    tick();
    drive_idle();
    @(negedge CLK);
    checks++; if (WB_VALID !== 1'b1) begin errors++; $display("FAIL fle_wb_valid got=%b exp=1", WB_VALID); end
    checks++; if (WB_RD !== 5'd4) begin errors++; $display("FAIL fle_wb_rd got=%0d exp=4", WB_RD); end
    tick();
    @(negedge CLK);
    checks++; if ({BUSY, WB_VALID} !== 2'b00) begin errors++; $display("FAIL fle_idle got=%b exp=00", {BUSY, WB_VALID}); end
    tick();
  endtask

  // FSQRT flushed at cycle 6; an illegal code in EXEC only stalls; FADD at 7 -> WB at 10.
  task automatic test_flush();
    issue(5'd13, 5'd2, 1'b1, 1'b0);
    tick();
    drive_idle();
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin ISSUE_VALID = 1'b1; FPU_SELECT = 5'd31; end
      if (c == 4) drive_idle();
      if (c == 6) FLUSH = 1'b1;
      if (c == 7) begin FLUSH = 1'b0; issue(5'd1, 5'd6, 1'b1, 1'b0); end
      if (c == 8) drive_idle();
      @(negedge CLK);
      checks++; if (WB_VALID !== (c == 10)) begin errors++; $display("FAIL flush_wb_valid c=%0d got=%b exp=%b", c, WB_VALID, (c == 10)); end
      if (c == 3) begin
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL exec_illegal_stall got=%b exp=1", STALL); end
        checks++; if (ILLEGAL_OP !== 1'b0) begin errors++; $display("FAIL exec_illegal_flag got=%b exp=0", ILLEGAL_OP); end
      end
      if (c == 6) begin
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_c6 got=%b exp=1", BUSY); end
      end
      if (c == 7) begin
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_idle_c7 got=%b exp=0", BUSY); end
        checks++; if (FPU_START !== 1'b1) begin errors++; $display("FAIL flush_fadd_start got=%b exp=1", FPU_START); end
      end
      if (c == 10) begin
        checks++; if (WB_RD !== 5'd6) begin errors++; $display("FAIL flush_fadd_rd got=%0d exp=6", WB_RD); end
      end
      tick();
    end
  endtask

  // Illegal codes in IDLE, plus the highest legal code (20, single-cycle).
  task automatic test_illegal();
    issue(5'd22, 5'd1, 1'b1, 1'b0);
    @(negedge CLK);
    checks++; if (ILLEGAL_OP !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", ILLEGAL_OP); end
    checks++; if (FPU_START !== 1'b0) begin errors++; $display("FAIL illegal_start got=%b exp=0", FPU_START); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL illegal_stall got=%b exp=0", STALL); end
    checks++; if (FPU_OP !== 5'd0) begin errors++; $display("FAIL illegal_op got=%0d exp=0", FPU_OP); end
    tick();
    FPU_SELECT = 5'd21;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL illegal_busy got=%b exp=0", BUSY); end
    checks++; if ({ILLEGAL_OP, FPU_START} !== 2'b10) begin errors++; $display("FAIL illegal21 got=%b exp=10", {ILLEGAL_OP, FPU_START}); end
    tick();
    issue(5'd20, 5'd11, 1'b1, 1'b0);
    @(negedge CLK);
    checks++; if ({ILLEGAL_OP, FPU_START} !== 2'b01) begin errors++; $display("FAIL legal20 got=%b exp=01", {ILLEGAL_OP, FPU_START}); end
    tick();
    drive_idle();
    @(negedge CLK);
    checks++; if (WB_VALID !== 1'b1) begin errors++; $display("FAIL legal20_wb got=%b exp=1", WB_VALID); end
    checks++; if (WB_RD !== 5'd11) begin errors++; $display("FAIL legal20_rd got=%0d exp=11", WB_RD); end
    tick();
    tick();
  endtask

  // FMADD (L=5) killed by RESET at cycle 2: no writeback, everything zero from cycle 3.
  task automatic test_reset_mid_op();
    issue(5'd14, 5'd8, 1'b1, 1'b1);
    tick();
    drive_idle();
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin RESET = 1'b1; issue(5'd1, 5'd12, 1'b1, 1'b0); end
      if (c == 3) begin RESET = 1'b0; drive_idle(); end
      @(negedge CLK);
      checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL rst_wb_valid c=%0d got=%b exp=0", c, WB_VALID); end
      if (c == 2) begin
        checks++; if ({FPU_START, STALL, ILLEGAL_OP} !== 3'b000) begin errors++; $display("FAIL rst_comb got=%b exp=000", {FPU_START, STALL, ILLEGAL_OP}); end
        checks++; if (FPU_OP !== 5'd0) begin errors++; $display("FAIL rst_fpu_op got=%0d exp=0", FPU_OP); end
      end
      if (c >= 3) begin
        checks++; if ({BUSY, WB_FREG_EN, WB_REG_EN} !== 3'b000) begin errors++; $display("FAIL rst_regs c=%0d got=%b exp=000", c, {BUSY, WB_FREG_EN, WB_REG_EN}); end
        checks++; if (WB_RD !== 5'd0) begin errors++; $display("FAIL rst_wb_rd c=%0d got=%0d exp=0", c, WB_RD); end
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    RESET = 1'b1;
    #1;
    test_reset();
    test_fadd();
    test_back_to_back();
    test_misc_compare();
    test_flush();
    test_illegal();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Sequences variable-latency FPU operations decoded by the control unit (FPU_SELECT encoding) and holds one operation in flight.
- Raises a structural-hazard stall to the issue stage while an operation is executing.
- Produces a timed writeback strobe with the latched destination register and register-file write enables.
- Sits between decode/issue and the FPU/writeback mux.

Parameters:
- LAT_ADD, 3, cycles from accept to writeback for FADD/FSUB
- LAT_MUL, 3, cycles for FMUL
- LAT_DIV, 12, cycles for FDIV
- LAT_SQRT, 14, cycles for FSQRT
- LAT_FMA, 5, cycles for FMADD/FMSUB/FNMADD/FNMSUB
- LAT_MISC, 1, cycles for all other legal codes (sign-inject, min/max, compare, convert, move, class)
- All latencies: legal range 1..31. The counter is 5 bits.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ISSUE_VALID  in  1  decode presents an FPU operation this cycle
- FPU_SELECT  in  5  operation code from the control unit
- RD  in  5  destination register index
- FREG_WRITE_EN_IN  in  1  operation writes the float register file
- REG_WRITE_EN_IN  in  1  operation writes the integer register file
- FLUSH  in  1  kill the in-flight operation (branch/trap)
- FPU_START  out  1  combinational; high in the accept cycle
- FPU_OP  out  5  combinational; equals FPU_SELECT when FPU_START is high, else 0
- STALL  out  1  combinational; issue must hold its operation
- ILLEGAL_OP  out  1  combinational; pulses for an unsupported code
- BUSY  out  1  registered; state != IDLE
- WB_VALID  out  1  registered; result ready for writeback this cycle
- WB_RD  out  5  registered; latched RD
- WB_FREG_EN  out  1  registered; WB_VALID & latched FREG_WRITE_EN_IN
- WB_REG_EN  out  1  registered; WB_VALID & latched REG_WRITE_EN_IN

Behaviour:
- States: IDLE, EXEC, WB. There is a 5-bit down-counter CNT.
- Latency class decode:
  - 00001, 00010 -> LAT_ADD
  - 00011 -> LAT_MUL
  - 00100 -> LAT_DIV
  - 01101 -> LAT_SQRT
  - 01110, 01111, 10000, 10001 -> LAT_FMA
  - 00000, 00101..01100, 10010..10100 -> LAT_MISC
  - 10101..11111 and any X/Z bit -> illegal
- Accept condition: ISSUE_VALID & legal code & ~FLUSH & state in {IDLE, WB}.
  - On accept: FPU_START=1, and RD and both write enables are latched.
  - If L=1: next state WB.
  - Else: next state EXEC with CNT=L-1.
- Writeback timing: WB_VALID is high exactly L cycles after the accept cycle, for exactly one cycle.
- EXEC:
  - CNT==1 -> WB.
  - Otherwise CNT decrements.
  - STALL = ISSUE_VALID.
  - No accept occurs in EXEC.
- WB:
  - WB_VALID=1.
  - A same-cycle accept (back-to-back) is allowed.
  - With no accept, next state is IDLE.
- Throughput: one operation per L cycles.
- STALL is never asserted in IDLE or WB.
- Illegal code with ISSUE_VALID in IDLE/WB: ILLEGAL_OP=1, no accept, no stall, state unchanged (WB still proceeds to IDLE). An illegal code in EXEC only stalls.
- FLUSH has priority over accept and over completion.
  - In EXEC: next state IDLE and WB_VALID never rises.
  - In WB: the current WB_VALID is unaffected (already registered), but no accept occurs that cycle.
- RESET has priority over everything. The next state is IDLE with CNT=0, and all registered outputs are 0: BUSY, WB_VALID, WB_RD, WB_FREG_EN, WB_REG_EN.
  - Reset mid-operation discards the operation with no writeback.
  - Combinational outputs are 0 while RESET is high.

Test Plan:
- Reset, then FADD (00001) issued at cycle 0 with RD=5, FREG_WRITE_EN_IN=1 -> FPU_START at cycle 0; WB_VALID, WB_FREG_EN=1, WB_RD=5 at cycle 3 only; BUSY cycles 1-3.
- FDIV at cycle 0, then ISSUE_VALID held with FMUL -> STALL high cycles 1-11; FMUL accepted at cycle 12 (WB cycle of FDIV); FMUL WB_VALID at cycle 15.
- FEQ (01010, REG_WRITE_EN_IN=1, FREG_WRITE_EN_IN=0) -> WB_REG_EN=1 and WB_FREG_EN=0 at cycle 1; a back-to-back FLE issued at cycle 1 -> WB at cycle 2.
- FSQRT accepted, FLUSH at cycle 6 -> IDLE at cycle 7, no WB_VALID through cycle 20; a new FADD at cycle 7 gives WB at cycle 10.
- FPU_SELECT=10110 with ISSUE_VALID in IDLE -> ILLEGAL_OP=1, FPU_START=0, STALL=0, BUSY stays 0.
- FMADD accepted, RESET at cycle 2 -> all outputs 0 from cycle 3; WB_VALID never asserted for that op.
